// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ADD,
        DONE
    } state_e;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic digit_ok(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder, shared across all digit positions.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        if (t > {1'b0, BCD_MAX}) begin
            s  = t[3:0] + BCD_ADJ;
            co = 1'b1;
        end else begin
            s  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_add_seq.sv
// Digit-serial BCD addition controller with operand validation.
// Optional BCD_ADD_SEQ_ERRIDX_EN adds err_idx_a/err_idx_b outputs.
module bcd_add_seq
    import bcd_pkg::*;
#(
    parameter  int NDIGITS = 4,
    localparam int IDXW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1,
    localparam int W       = BCD_W * NDIGITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    op_a,
    input  logic [W-1:0]    op_b,
    input  logic            cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    sum,
    output logic            cout,
    output logic            err_a,
    output logic            err_b,
`ifdef BCD_ADD_SEQ_ERRIDX_EN
    output logic [IDXW-1:0] err_idx_a,
    output logic [IDXW-1:0] err_idx_b,
`endif
    output logic            busy
);

    localparam logic [IDXW-1:0] LAST = IDXW'(NDIGITS - 1);

    state_e            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              err_a_q;
    logic              err_b_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [NDIGITS-1:0] bad_a;
    logic [NDIGITS-1:0] bad_b;
    logic [3:0]         dig_a;
    logic [3:0]         dig_b;
    logic [3:0]         dig_s;
    logic               dig_co;

    always_comb begin
        bad_a = '0;
        bad_b = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            bad_a[i] = !digit_ok(a_q[i*BCD_W +: BCD_W]);
            bad_b[i] = !digit_ok(b_q[i*BCD_W +: BCD_W]);
        end
    end

    assign dig_a = a_q[int'(idx_q)*BCD_W +: BCD_W];
    assign dig_b = b_q[int'(idx_q)*BCD_W +: BCD_W];

    bcd_digit_add u_dig (
        .a  (dig_a),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

`ifdef BCD_ADD_SEQ_ERRIDX_EN
    logic [IDXW-1:0] eia_d;
    logic [IDXW-1:0] eib_d;
    logic [IDXW-1:0] eia_q;
    logic [IDXW-1:0] eib_q;

    // Scan downward so the lowest offending index wins.
    always_comb begin
        eia_d = '0;
        eib_d = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            if (bad_a[i]) eia_d = IDXW'(i);
            if (bad_b[i]) eib_d = IDXW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eia_q <= '0;
            eib_q <= '0;
        end else if (state_q == CHECK) begin
            eia_q <= eia_d;
            eib_q <= eib_d;
        end
    end

    assign err_idx_a = eia_q;
    assign err_idx_b = eib_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_a_q     <= 1'b0;
            err_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        carry_q    <= cin;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CHECK;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (|bad_a || |bad_b) begin
                        err_a_q <= |bad_a;
                        err_b_q <= |bad_b;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        err_a_q <= 1'b0;
                        err_b_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q[int'(idx_q)*BCD_W +: BCD_W] <= dig_s;
                    carry_q <= dig_co;
                    if (idx_q == LAST) begin
                        cout_q  <= dig_co;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    // Result becomes visible one cycle after entering DONE.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_add_seq.sv
// Self-checking bench for bcd_add_seq against a decimal-arithmetic model.
module tb_bcd_add_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         err_a;
    logic         err_b;
    logic         busy;
`ifdef BCD_ADD_SEQ_ERRIDX_EN
    logic [1:0]   err_idx_a;
    logic [1:0]   err_idx_b;
`endif

    int tests = 0;
    int fails = 0;

    bcd_add_seq #(.NDIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err_a     (err_a),
        .err_b     (err_b),
`ifdef BCD_ADD_SEQ_ERRIDX_EN
        .err_idx_a (err_idx_a),
        .err_idx_b (err_idx_b),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: decode to integers, add decimally, re-encode.
    function automatic void model(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic         c,
        output logic [W-1:0] s,
        output logic         co,
        output logic         ea,
        output logic         eb,
        output int           ia,
        output int           ib
    );
        int va, vb, tot, lim;
        ea = 0; eb = 0; ia = 0; ib = 0;
        va = 0; vb = 0; lim = 1;
        for (int i = N - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 9) begin ea = 1; ia = i; end
            if (b[4*i +: 4] > 9) begin eb = 1; ib = i; end
            va = va * 10 + int'(a[4*i +: 4]);
            vb = vb * 10 + int'(b[4*i +: 4]);
            lim = lim * 10;
        end
        s = '0;
        co = 0;
        if (!ea && !eb) begin
            tot = va + vb + int'(c);
            co = (tot >= lim);
            tot = tot % lim;
            for (int i = 0; i < N; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        int n;
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release: out_valid=%0b in_ready=%0b busy=%0b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic c);
        logic [W-1:0] es;
        logic eco, eea, eeb;
        int eia, eib, lat, elat;
        model(a, b, c, es, eco, eea, eeb, eia, eib);
        elat = (eea || eeb) ? 2 : N + 2;
        accept(a, b, c);
        wait_out(lat);
        tests++;
        if (lat !== elat || sum !== es || cout !== eco ||
            err_a !== eea || err_b !== eeb) begin
            fails++;
            $display("FAIL %s: a=%h b=%h c=%0b got lat=%0d sum=%h co=%0b ea=%0b eb=%0b required lat=%0d sum=%h co=%0b ea=%0b eb=%0b",
                     nm, a, b, c, lat, sum, cout, err_a, err_b,
                     elat, es, eco, eea, eeb);
        end
`ifdef BCD_ADD_SEQ_ERRIDX_EN
        tests++;
        if (int'(err_idx_a) != eia || int'(err_idx_b) != eib) begin
            fails++;
            $display("FAIL %s_idx: got %0d %0d required %0d %0d",
                     nm, err_idx_a, err_idx_b, eia, eib);
        end
`endif
        release_out();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (in_ready !== 0 || out_valid !== 0 || sum !== '0 || cout !== 0 ||
            err_a !== 0 || err_b !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL reset_vals: rdy=%0b ov=%0b sum=%h co=%0b ea=%0b eb=%0b busy=%0b required all 0",
                     in_ready, out_valid, sum, cout, err_a, err_b, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_check("dir_1234_5678", 16'h1234, 16'h5678, 1'b0);
        run_check("dir_9999_0001", 16'h9999, 16'h0001, 1'b0);
        run_check("dir_zero_cin", 16'h0000, 16'h0000, 1'b1);
        run_check("dir_9999_9999_c", 16'h9999, 16'h9999, 1'b1);
    endtask

    task automatic test_errors();
        run_check("err_both", 16'h12A4, 16'h00F0, 1'b0);
        run_check("err_a_only", 16'hF000, 16'h1111, 1'b1);
        run_check("err_b_only", 16'h2222, 16'h000B, 1'b0);
    endtask

    task automatic test_hold();
        int lat;
        logic [W-1:0] s0;
        logic c0, ea0, eb0;
        accept(16'h0456, 16'h0789, 1'b0);
        wait_out(lat);
        s0 = sum; c0 = cout; ea0 = err_a; eb0 = err_b;
        tests++;
        if (s0 !== 16'h1245 || c0 !== 1'b0) begin
            fails++;
            $display("FAIL hold_val: sum=%h co=%0b required 1245 0", s0, c0);
        end
        op_a = 16'h1111; op_b = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1 || in_ready !== 0 || sum !== s0 ||
                cout !== c0 || err_a !== ea0 || err_b !== eb0) begin
                fails++;
                $display("FAIL hold_cycle%0d: ov=%0b rdy=%0b sum=%h required 1 0 %h",
                         i, out_valid, in_ready, sum, s0);
            end
        end
        in_valid = 1'b0;
        release_out();
    endtask

    task automatic test_reset_mid();
        accept(16'h1234, 16'h5678, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 0 || sum !== '0 || busy !== 0 || in_ready !== 0) begin
            fails++;
            $display("FAIL reset_mid: ov=%0b sum=%h busy=%0b rdy=%0b required 0 0 0 0",
                     out_valid, sum, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_check("after_reset", 16'h0005, 16'h0005, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                a[4*i +: 4] = ($urandom_range(0, 19) == 0) ?
                              4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                b[4*i +: 4] = ($urandom_range(0, 19) == 0) ?
                              4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            run_check("random", a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] exp;
        logic [W-1:0] es, a, b;
        logic eco, eea, eeb, acc, res;
        int eia, eib, sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin
            a[4*i +: 4] = 4'($urandom_range(0, 9));
            b[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        op_a = a; op_b = b; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 8 && cyc < 400) begin
            acc = in_valid && in_ready;
            res = out_valid && out_ready;
            if (in_ready && out_valid) begin
                tests++; fails++;
                $display("FAIL b2b_overlap: in_ready=1 out_valid=1 required not both");
            end
            if (res) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                tests++;
                if ({cout, sum} !== exp) begin
                    fails++;
                    $display("FAIL b2b_result%0d: got %b_%h required %b_%h",
                             got, cout, sum, exp[W], exp[W-1:0]);
                end
                got++;
            end
            if (acc) begin
                model(op_a, op_b, cin, es, eco, eea, eeb, eia, eib);
                q.push_back({eco, es});
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent == 8) in_valid = 1'b0;
                for (int i = 0; i < N; i++) begin
                    a[4*i +: 4] = 4'($urandom_range(0, 9));
                    b[4*i +: 4] = 4'($urandom_range(0, 9));
                end
                op_a = a; op_b = b; cin = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (got != 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d results required 8", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_add_seq.md
Name: bcd_add_seq

Overview:
- Digit-serial BCD addition controller for the ejercicio_5 BCD datapath.
- Accepts two packed multi-digit BCD operands over a valid/ready handshake, and validates every digit (each must be 0..9).
- Sequences a single-digit BCD adder over the operands, least-significant digit first, propagating carry.
- Returns the sum, or per-operand error flags, over a second valid/ready handshake.

Parameters:
- NDIGITS, 4, number of BCD digits per operand; legal range 1..16.
- IDXW, $clog2(NDIGITS) (minimum 1), width of the digit index counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- op_a  in  4*NDIGITS  operand A, packed BCD; digit i is bits [4i+3:4i].
- op_b  in  4*NDIGITS  operand B, packed BCD.
- cin  in  1  carry-in, captured together with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  4*NDIGITS  packed BCD sum.
- cout  out  1  decimal carry-out.
- err_a  out  1  op_a contained a digit greater than 9.
- err_b  out  1  op_b contained a digit greater than 9.
- busy  out  1  controller is not in the IDLE state.

Behaviour:
- Reset values: in_ready=0 while rst_n is low. in_ready=1 on the first clock after release. out_valid=0, sum=0, cout=0, err_a=0, err_b=0, busy=0. The FSM resets to IDLE.
- All outputs are registered.
- FSM states: IDLE, CHECK, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: capture op_a, op_b and cin, then go to CHECK.
- CHECK (one cycle):
  - Compare every digit of both captured operands against 9.
  - Any invalid digit: set err_a/err_b accordingly, set sum=0 and cout=0, go to DONE. out_valid rises at edge k+2.
  - Otherwise: clear both err flags, set idx=0, carry=cin, go to ADD.
- ADD (one digit per cycle):
  - t = a[idx] + b[idx] + carry, 5-bit.
  - If t>9: digit = (t+6)[3:0] and carry=1. Otherwise: digit = t[3:0] and carry=0.
  - Write the digit into sum slot idx.
  - At idx==NDIGITS-1: cout=carry, go to DONE. Otherwise idx+1.
  - Valid result: out_valid rises at edge k+NDIGITS+2.
- DONE:
  - out_valid=1; sum, cout, err_a and err_b stay stable while out_ready is low.
  - On out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle accept.
- sum, cout and the err flags keep their last values after DONE until the next CHECK or ADD overwrites them.
- in_ready=0 in CHECK, ADD and DONE; in_valid is ignored in those states.
- Reset asserted mid-operation aborts immediately. All registers return to their reset values, and a partial sum is never presented.
- If both operands are invalid, both flags are set. Carry-out from the top digit goes only to cout; sum does not wrap into extra digits.
- NDIGITS=1: ADD lasts exactly one cycle.

Optional Feature:
- Macro: BCD_ADD_SEQ_ERRIDX_EN.
- With the macro defined:
  - Two extra outputs, err_idx_a and err_idx_b, each IDXW wide.
  - Each holds the lowest digit index with a value greater than 9 in its operand.
  - Each is 0 when its operand is valid.
  - Both are registered in CHECK and reset to 0.
- Without the macro: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bcd_pkg contains:
  - state enum (IDLE, CHECK, ADD, DONE);
  - BCD_W=4;
  - BCD_MAX=4'd9;
  - BCD_ADJ=4'd6;
  - a digit-valid function.
- Sub-module bcd_digit_add: combinational.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co.
  - Instantiated once and shared across digits by the FSM.

Test Plan:
- op_a=0x1234, op_b=0x5678, cin=0 -> sum=0x6912, cout=0, no err flags, out_valid 6 cycles after accept.
- op_a=0x9999, op_b=0x0001, cin=0 -> sum=0x0000, cout=1. op_a=op_b=0x0000, cin=1 -> sum=0x0001, cout=0.
- op_a=0x12A4, op_b=0x00F0 -> err_a=1, err_b=1, sum=0, cout=0, out_valid 2 cycles after accept. With BCD_ADD_SEQ_ERRIDX_EN: err_idx_a=1, err_idx_b=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and flags stable, in_ready=0, and a new in_valid is ignored. Then raise out_ready -> IDLE, with in_ready=1 the following cycle.
- Pulse rst_n low during ADD at idx=2 -> out_valid=0, sum=0, busy=0 immediately. A fresh 0x0005+0x0005 then yields sum=0x0010.
- Back-to-back transactions with in_valid held high -> each one is accepted only after the previous out_ready handshake, and results come out in order.
